axi_slave_mem: RTL and testbench

//  Parametrised AXI3 slave memory; the DUV-side endpoint for the tbbfm AXI channels.

---
 rtl/axi_slave_mem.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave memory, independent write/read burst engines; WRAP bursts enabled by AXI_WRAP_BURST_EN
module axi_slave_mem #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ID_W-1:0]      AWID,
    input  logic [ADDR_W-1:0]    AWADDR,
    input  logic [LEN_W-1:0]     AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [ID_W-1:0]      WID,
    input  logic [WIDTH-1:0]     WDATA,
    input  logic [WIDTH/8-1:0]   WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [ID_W-1:0]      BID,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ID_W-1:0]      ARID,
    input  logic [ADDR_W-1:0]    ARADDR,
    input  logic [LEN_W-1:0]     ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [ID_W-1:0]      RID,
    output logic [WIDTH-1:0]     RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
);
    localparam int NB    = WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
`ifdef AXI_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> OFF) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a[OFF +: IDX_W];
    endfunction

    // Oversized beats, reserved bursts and unsupported WRAP shapes poison the whole burst
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [LEN_W-1:0] len);
        logic wrap_ok;
        wrap_ok = WRAP_EN && (len != '0) && ((len & (len + LEN_W'(1))) == '0);
        return (size > 3'(OFF)) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok);
    endfunction

    // WRAP keeps the address inside a (len+1)<<size aligned window
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                                    input logic [1:0] burst, input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] span, nxt;
        span = (ADDR_W'(len) + ADDR_W'(1)) << size;
        nxt  = a + (ADDR_W'(1) << size);
        if (burst == 2'b00)
            nxt = a;
        else if (burst == 2'b10 && WRAP_EN)
            nxt = (a & ~(span - ADDR_W'(1))) | (nxt & (span - ADDR_W'(1)));
        return nxt;
    endfunction

    logic live;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [ID_W-1:0]   w_id, r_id;
    logic [ADDR_W-1:0] w_addr, r_addr, f_addr;
    logic [LEN_W-1:0]  w_len, w_cnt, r_len, r_cnt;
    logic [2:0]        w_size, r_size;
    logic [1:0]        w_burst, r_burst, rresp_q;
    logic              w_bad, w_slv, w_dec, r_bad, f_bad;
    logic [WIDTH-1:0]  rdata_q;
    logic              w_last, w_hs, w_commit, r_last, ar_hs, r_adv;

    assign w_last   = (w_cnt == w_len);
    assign w_hs     = WVALID && WREADY;
    assign w_commit = w_hs && !w_bad && (WID == w_id) && in_range(w_addr);
    assign r_last   = (r_cnt == r_len);
    assign ar_hs    = ARVALID && ARREADY;
    assign r_adv    = (r_state == R_DATA) && RREADY && !r_last;
    assign f_addr   = ar_hs ? ARADDR : next_addr(r_addr, r_size, r_burst, r_len);
    assign f_bad    = ar_hs ? burst_bad(ARSIZE, ARBURST, ARLEN) : r_bad;

    // Keeps the ready outputs low while reset is held and for the release cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Write engine state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write engine next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (AWVALID && AWREADY) w_next = W_DATA;
            W_DATA:  if (WVALID && w_last)   w_next = W_RESP;
            W_RESP:  if (BREADY)             w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write engine outputs; DECERR outranks SLVERR in the burst response
    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = OKAY;
        case (w_state)
            W_IDLE: AWREADY = live;
            W_DATA: WREADY  = 1'b1;
            W_RESP: begin
                BVALID = 1'b1;
                BID    = w_id;
                BRESP  = w_dec ? DECERR : (w_slv ? SLVERR : OKAY);
            end
            default: ;
        endcase
    end

    // Write burst bookkeeping: latched command, beat count and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0; w_burst <= '0;
            w_cnt <= '0; w_bad <= 1'b0; w_slv <= 1'b0; w_dec <= 1'b0;
        end else if (w_state == W_IDLE && AWVALID && AWREADY) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_bad   <= burst_bad(AWSIZE, AWBURST, AWLEN);
            w_slv   <= burst_bad(AWSIZE, AWBURST, AWLEN);
            w_dec   <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + LEN_W'(1);
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            if ((WLAST != w_last) || (WID != w_id)) w_slv <= 1'b1;
            if (!in_range(w_addr))                  w_dec <= 1'b1;
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit)
            for (int i = 0; i < NB; i++)
                if (WSTRB[i]) mem[word_of(w_addr)][i*8 +: 8] <= WDATA[i*8 +: 8];
    end

    // Read engine state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read engine next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)            r_next = R_DATA;
            R_DATA:  if (RREADY && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read engine outputs
    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = OKAY;
        RLAST   = 1'b0;
        case (r_state)
            R_IDLE: ARREADY = live;
            R_DATA: begin
                RVALID = 1'b1;
                RID    = r_id;
                RDATA  = rdata_q;
                RRESP  = rresp_q;
                RLAST  = r_last;
            end
            default: ;
        endcase
    end

    // Read beat fetch: data registered on AR accept and on each advance, so a same-edge write is not seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0;
            r_cnt <= '0; r_bad <= 1'b0; rdata_q <= '0; rresp_q <= OKAY;
        end else begin
            if (ar_hs) begin
                r_id    <= ARID;
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= ARBURST;
                r_cnt   <= '0;
                r_bad   <= f_bad;
            end else if (r_adv) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_addr <= f_addr;
            end
            if (ar_hs || r_adv) begin
                if (!in_range(f_addr)) begin
                    rdata_q <= '0;
                    rresp_q <= DECERR;
                end else if (f_bad) begin
                    rdata_q <= '0;
                    rresp_q <= SLVERR;
                end else begin
                    rdata_q <= mem[word_of(f_addr)];
                    rresp_q <= OKAY;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - scoreboard bench for axi_slave_mem
module tb_axi_slave_mem;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  AWID = '0, WID = '0, BID, ARID = '0, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic        BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;

    always #5 clk = ~clk;

    axi_slave_mem #(.WIDTH(32), .ADDR_W(32), .ID_W(4), .LEN_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bresp_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [16];
    rbeat_t      r_q[$];
    bresp_t      b_q[$];

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [2:0] size,
                                              input logic [1:0] burst, input int len);
        logic [31:0] bytes, span, base;
        bytes = 32'd1 << size;
        span  = 32'(len + 1) * bytes;
        base  = a - (a % span);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) return base + ((a - base + 32'(i) * bytes) % span);
        return a + 32'(i) * bytes;
    endfunction

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int last_at, input int badid_at, input logic whole_bad,
                               input logic [1:0] exp_resp, input int bstall, input string tag);
        int          n;
        logic [31:0] a;
        bresp_t      exp, hold;
        b_q.push_back('{id: id, resp: exp_resp});
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, size, burst, len);
            if (!whole_bad && i != badid_at && (a >> 2) < DEPTH)
                for (int j = 0; j < 4; j++)
                    if (strb[j]) model[a >> 2][j*8 +: 8] = wbuf[i][j*8 +: 8];
        end
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        total++;
        if (AWREADY !== 1'b1) begin bad++; $display("FAIL %s awready got=%b want=1", tag, AWREADY); end
        @(posedge clk); @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            WID = (i == badid_at) ? ~id : id; WDATA = wbuf[i]; WSTRB = strb;
            WLAST = (i == last_at); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            total++;
            if (WREADY !== 1'b1) begin bad++; $display("FAIL %s wready beat %0d got=%b want=1", tag, i, WREADY); end
            @(posedge clk); @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = (bstall == 0);
        n = 0;
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        hold = '{id: BID, resp: BRESP};
        for (int k = 0; k < bstall; k++) begin
            @(negedge clk);
            total++;
            if ({BVALID, BID, BRESP} !== {1'b1, hold}) begin
                bad++; $display("FAIL %s b_hold cycle %0d got=%b/%h/%h want=1/%h/%h", tag, k, BVALID, BID, BRESP, hold.id, hold.resp);
            end
        end
        BREADY = 1'b1;
        exp = b_q.pop_front();
        total++;
        if ({BVALID, BID, BRESP} !== {1'b1, exp}) begin
            bad++; $display("FAIL %s bresp got valid=%b id=%h resp=%b want valid=1 id=%h resp=%b", tag, BVALID, BID, BRESP, exp.id, exp.resp);
        end
        @(posedge clk); @(negedge clk);
        BREADY = 1'b0;
        total++;
        if (BVALID !== 1'b0) begin bad++; $display("FAIL %s b_drop got=%b want=0", tag, BVALID); end
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input logic whole_bad,
                              input int stall_at, input int stall_n, input int abort_at, input string tag);
        int          n, gaps;
        logic [31:0] a;
        rbeat_t      exp, hold;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, size, burst, len);
            if ((a >> 2) >= DEPTH) r_q.push_back('{id: id, data: 32'h0, resp: 2'b11, last: (i == len)});
            else if (whole_bad)    r_q.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (i == len)});
            else                   r_q.push_back('{id: id, data: model[a >> 2], resp: 2'b00, last: (i == len)});
        end
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        total++;
        if (ARREADY !== 1'b1) begin bad++; $display("FAIL %s arready got=%b want=1", tag, ARREADY); end
        @(posedge clk); @(negedge clk);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        gaps = 0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!RVALID && n < 50) begin @(negedge clk); n++; end
            gaps += n;
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                total++;
                if ({RVALID, ARREADY, AWREADY, RDATA, RLAST} !== 35'h0) begin
                    bad++; $display("FAIL %s reset_outputs got rvalid=%b arready=%b awready=%b rdata=%h rlast=%b want all 0", tag, RVALID, ARREADY, AWREADY, RDATA, RLAST);
                end
                r_q.delete();
                RREADY = 1'b0;
                return;
            end
            if (i == stall_at) begin
                RREADY = 1'b0;
                hold = '{id: RID, data: RDATA, resp: RRESP, last: RLAST};
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    total++;
                    if ({RVALID, RID, RDATA, RRESP, RLAST} !== {1'b1, hold}) begin
                        bad++; $display("FAIL %s r_hold cycle %0d got=%b/%h/%h/%b/%b want=1/%h/%h/%b/%b", tag, k, RVALID, RID, RDATA, RRESP, RLAST, hold.id, hold.data, hold.resp, hold.last);
                    end
                end
                RREADY = 1'b1;
            end
            exp = r_q.pop_front();
            total++;
            if ({RVALID, RID, RDATA, RRESP, RLAST} !== {1'b1, exp}) begin
                bad++; $display("FAIL %s rbeat %0d got valid=%b id=%h data=%h resp=%b last=%b want valid=1 id=%h data=%h resp=%b last=%b", tag, i, RVALID, RID, RDATA, RRESP, RLAST, exp.id, exp.data, exp.resp, exp.last);
            end
            @(posedge clk); @(negedge clk);
        end
        RREADY = 1'b0;
        total++;
        if (gaps != 0) begin bad++; $display("FAIL %s r_latency_gaps got=%0d want=0", tag, gaps); end
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        total++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
            bad++; $display("FAIL reset_state got aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0", AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({AWREADY, ARREADY} !== 2'b11) begin bad++; $display("FAIL reset_release got aw=%b ar=%b want 1 1", AWREADY, ARREADY); end
    endtask

    task automatic test_incr_fixed;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        write_burst(4'd5, 32'h10, 3, 3'd2, 2'b01, 4'hF, 3, -1, 1'b0, 2'b00, 0, "incr_wr");
        read_burst(4'd5, 32'h10, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "incr_rd");
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hB0 + i;
        write_burst(4'd2, 32'h80, 2, 3'd2, 2'b00, 4'hF, 2, -1, 1'b0, 2'b00, 0, "fixed_wr");
        read_burst(4'd2, 32'h80, 2, 3'd2, 2'b00, 1'b0, -1, 0, -1, "fixed_rd");
    endtask

    task automatic test_strobe;
        wbuf[0] = 32'hFFFF_FFFF;
        write_burst(4'd1, 32'h0, 0, 3'd2, 2'b01, 4'hF, 0, -1, 1'b0, 2'b00, 0, "strobe_wr1");
        wbuf[0] = 32'h1234_5678;
        write_burst(4'd1, 32'h0, 0, 3'd2, 2'b01, 4'b0101, 0, -1, 1'b0, 2'b00, 0, "strobe_wr2");
        read_burst(4'd1, 32'h0, 0, 3'd2, 2'b01, 1'b0, -1, 0, -1, "strobe_rd");
    endtask

    task automatic test_backpressure;
        read_burst(4'd7, 32'h10, 3, 3'd2, 2'b01, 1'b0, 1, 5, -1, "rready_stall");
        wbuf[0] = 32'h5A5A_0001;
        write_burst(4'd9, 32'h20, 0, 3'd2, 2'b01, 4'hF, 0, -1, 1'b0, 2'b00, 3, "bready_stall");
    endtask

    task automatic test_errors;
        wbuf[0] = 32'hCAFE_0040;
        write_burst(4'd3, 32'h40, 0, 3'd2, 2'b01, 4'hF, 0, -1, 1'b0, 2'b00, 0, "err_pre");
        wbuf[0] = 32'hDEAD_BEEF;
        write_burst(4'd3, DEPTH * 4, 0, 3'd2, 2'b01, 4'hF, 0, -1, 1'b0, 2'b11, 0, "decerr_wr");
        read_burst(4'd3, 32'h0, 0, 3'd2, 2'b01, 1'b0, -1, 0, -1, "decerr_alias");
        read_burst(4'd3, DEPTH * 4, 0, 3'd2, 2'b01, 1'b0, -1, 0, -1, "decerr_rd");
        write_burst(4'd4, 32'h40, 0, 3'd3, 2'b01, 4'hF, 0, -1, 1'b1, 2'b10, 0, "size_wr");
        read_burst(4'd4, 32'h40, 0, 3'd2, 2'b01, 1'b0, -1, 0, -1, "size_unchanged");
        read_burst(4'd4, 32'h40, 0, 3'd3, 2'b01, 1'b1, -1, 0, -1, "size_rd");
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5000 + i;
        write_burst(4'd6, 32'h50, 3, 3'd2, 2'b01, 4'hF, 1, -1, 1'b0, 2'b10, 0, "wlast_early");
        read_burst(4'd6, 32'h50, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "wlast_rd");
        for (int i = 0; i < 2; i++) wbuf[i] = 32'h6000 + i;
        write_burst(4'd8, 32'h60, 1, 3'd2, 2'b01, 4'hF, 1, -1, 1'b0, 2'b00, 0, "wid_pre");
        for (int i = 0; i < 2; i++) wbuf[i] = 32'h6100 + i;
        write_burst(4'd8, 32'h60, 1, 3'd2, 2'b01, 4'hF, 1, 1, 1'b0, 2'b10, 0, "wid_bad");
        read_burst(4'd8, 32'h60, 1, 3'd2, 2'b01, 1'b0, -1, 0, -1, "wid_rd");
        for (int i = 0; i < 2; i++) wbuf[i] = 32'hE000 + i;
        write_burst(4'd2, (DEPTH - 1) * 4, 1, 3'd2, 2'b01, 4'hF, 1, -1, 1'b0, 2'b11, 0, "edge_wr");
        read_burst(4'd2, (DEPTH - 1) * 4, 1, 3'd2, 2'b01, 1'b0, -1, 0, -1, "edge_rd");
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        write_burst(4'd1, 32'h30, 3, 3'd2, 2'b01, 4'hF, 3, -1, 1'b0, 2'b00, 0, "wrap_pre");
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + i;
`ifdef AXI_WRAP_BURST_EN
        write_burst(4'd1, 32'h38, 3, 3'd2, 2'b10, 4'hF, 3, -1, 1'b0, 2'b00, 0, "wrap_wr");
        read_burst(4'd1, 32'h30, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "wrap_lin");
        read_burst(4'd1, 32'h38, 3, 3'd2, 2'b10, 1'b0, -1, 0, -1, "wrap_rd");
        write_burst(4'd1, 32'h38, 2, 3'd2, 2'b10, 4'hF, 2, -1, 1'b1, 2'b10, 0, "wrap_badlen");
`else
        write_burst(4'd1, 32'h38, 3, 3'd2, 2'b10, 4'hF, 3, -1, 1'b1, 2'b10, 0, "wrap_off_wr");
        read_burst(4'd1, 32'h30, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "wrap_off_lin");
        read_burst(4'd1, 32'h38, 3, 3'd2, 2'b10, 1'b1, -1, 0, -1, "wrap_off_rd");
`endif
        write_burst(4'd1, 32'h30, 0, 3'd2, 2'b11, 4'hF, 0, -1, 1'b1, 2'b10, 0, "reserved_wr");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h2000_0000 + 32'(i * 17);
        fork
            write_burst(4'hA, 32'h200, 7, 3'd2, 2'b01, 4'hF, 7, -1, 1'b0, 2'b00, 0, "b2b_wr");
            read_burst(4'hB, 32'h10, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "b2b_rd");
        join
        read_burst(4'hC, 32'h200, 7, 3'd2, 2'b01, 1'b0, -1, 0, -1, "b2b_rdback");
    endtask

    task automatic test_reset_mid_read;
        read_burst(4'hD, 32'h200, 3, 3'd2, 2'b01, 1'b0, -1, 0, 2, "rst_mid");
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ARREADY !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b want=1", ARREADY); end
        read_burst(4'hE, 32'h10, 3, 3'd2, 2'b01, 1'b0, -1, 0, -1, "rst_new");
    endtask

    initial begin
        test_reset;
        test_incr_fixed;
        test_strobe;
        test_backpressure;
        test_errors;
        test_wrap;
        test_back_to_back;
        test_reset_mid_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
